uart_frame_parser: RTL and testbench

//  Sits directly downstream of the UART receiver. Consumes its byte stream (one-cycle done strobe per byte).

---
 rtl/uart_pkg.sv | 33 +++
 rtl/uart_frame_parser_if.sv | 32 +++
 rtl/uart_frame_parser_frame_buf.sv | 35 +++
 rtl/uart_frame_parser.sv | 203 ++++++++++++++++++++
 tb/tb_uart_frame_parser.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared definitions for the UART frame parser: FSM state
//                encoding, error codes, default sync marker and a pointer
//                width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        ST_HUNT    = 3'd0,
        ST_LEN     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CHK     = 3'd3,
        ST_DRAIN   = 3'd4
    } state_t;

    localparam logic [2:0] c_err_none    = 3'd0;
    localparam logic [2:0] c_err_bad_len = 3'd1;
    localparam logic [2:0] c_err_bad_chk = 3'd2;
    localparam logic [2:0] c_err_timeout = 3'd3;
    localparam logic [2:0] c_err_overrun = 3'd4;

    localparam logic [7:0] c_sync_byte_default = 8'hA5;

    // Width of a counter/pointer addressing 0..depth-1, never below one bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_frame_parser_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_frame_parser_if
//  Description : Byte-stream bundle around the frame parser.
//                Ports: din/din_valid (receiver bytes in), dout/dout_valid/
//                dout_ready/dout_last (validated payload out), frame_ok,
//                frame_err, err_code (status).
//                master = parser side, slave = environment side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_frame_parser_if;
    logic [7:0] din;
    logic       din_valid;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready;
    logic       dout_last;
    logic       frame_ok;
    logic       frame_err;
    logic [2:0] err_code;

    modport master (
        input  din, din_valid, dout_ready,
        output dout, dout_valid, dout_last, frame_ok, frame_err, err_code
    );

    modport slave (
        output din, din_valid, dout_ready,
        input  dout, dout_valid, dout_last, frame_ok, frame_err, err_code
    );
endinterface
`default_nettype wire

// File: rtl/uart_frame_parser_frame_buf.sv
`default_nettype none
// ============================================================================
//  Module      : frame_buf
//  Description : DEPTH x 8 payload store, one synchronous write port and one
//                asynchronous read port. Contents are not reset.
//                Ports: clk, i_wr_en, i_wr_addr, i_wr_data, i_rd_addr,
//                o_rd_data.
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_buf
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int PTR_W = ptr_width(DEPTH)
) (
    input  wire logic             clk,
    input  wire logic             i_wr_en,
    input  wire logic [PTR_W-1:0] i_wr_addr,
    input  wire logic [7:0]       i_wr_data,
    input  wire logic [PTR_W-1:0] i_rd_addr,
    output logic      [7:0]       o_rd_data
);

    logic [7:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule
`default_nettype wire

// File: rtl/uart_frame_parser.sv
`default_nettype none
// ============================================================================
//  Module      : uart_frame_parser
//  Description : Frames the UART receiver byte stream as SYNC, LEN, payload,
//                CHK; buffers and checksums the payload and drains a
//                validated frame on a valid/ready byte stream. Bad length,
//                bad checksum, inter-byte timeout and overrun during drain
//                are reported on frame_err/err_code.
//                Ports: clk, rst (async, active high), bus (master modport).
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_frame_parser
    import uart_pkg::*;
#(
    parameter int         MAX_LEN      = 16,
    parameter logic [7:0] SYNC_BYTE    = c_sync_byte_default,
    parameter int         TIMEOUT_CLKS = 20_000
) (
    input  wire logic            clk,
    input  wire logic            rst,
    uart_frame_parser_if.master  bus
);

    localparam int             PTR_W       = ptr_width(MAX_LEN);
    localparam int             TIMER_W     = ptr_width(TIMEOUT_CLKS);
    localparam logic [7:0]     c_max_len   = 8'(MAX_LEN);
    localparam logic [TIMER_W-1:0] c_timer_last = TIMER_W'(TIMEOUT_CLKS - 1);

    state_t               r_state,     w_state_nxt;
    logic [7:0]           r_len,       w_len_nxt;
    logic [7:0]           r_sum,       w_sum_nxt;
    logic [PTR_W-1:0]     r_wr_ptr,    w_wr_ptr_nxt;
    logic [PTR_W-1:0]     r_rd_ptr,    w_rd_ptr_nxt;
    logic [TIMER_W-1:0]   r_timer,     w_timer_nxt;
    logic                 r_frame_ok,  w_frame_ok_nxt;
    logic                 r_frame_err, w_frame_err_nxt;
    logic [2:0]           r_err_code,  w_err_code_nxt;

    logic                 w_buf_we;
    logic [7:0]           w_rd_data;
    logic                 w_timeout;
    logic                 w_draining;
    logic                 w_rd_last;

    frame_buf #(
        .DEPTH (MAX_LEN),
        .PTR_W (PTR_W)
    ) u_frame_buf (
        .clk       (clk),
        .i_wr_en   (w_buf_we),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (bus.din),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_data)
    );

    assign w_timeout  = (r_timer == c_timer_last);
    assign w_draining = (r_state == ST_DRAIN);
    assign w_rd_last  = (8'(r_rd_ptr) == (r_len - 8'd1));

    // Drain outputs are combinational from the read pointer so the first
    // byte is already presented in the cycle frame_ok pulses.
    assign bus.dout_valid = w_draining;
    assign bus.dout       = w_draining ? w_rd_data : 8'h00;
    assign bus.dout_last  = w_draining && w_rd_last;
    assign bus.frame_ok   = r_frame_ok;
    assign bus.frame_err  = r_frame_err;
    assign bus.err_code   = r_err_code;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_HUNT;
            r_len       <= 8'h00;
            r_sum       <= 8'h00;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_timer     <= '0;
            r_frame_ok  <= 1'b0;
            r_frame_err <= 1'b0;
            r_err_code  <= c_err_none;
        end else begin
            r_state     <= w_state_nxt;
            r_len       <= w_len_nxt;
            r_sum       <= w_sum_nxt;
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_timer     <= w_timer_nxt;
            r_frame_ok  <= w_frame_ok_nxt;
            r_frame_err <= w_frame_err_nxt;
            r_err_code  <= w_err_code_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_len_nxt       = r_len;
        w_sum_nxt       = r_sum;
        w_wr_ptr_nxt    = r_wr_ptr;
        w_rd_ptr_nxt    = r_rd_ptr;
        w_timer_nxt     = r_timer;
        w_frame_ok_nxt  = 1'b0;
        w_frame_err_nxt = 1'b0;
        w_err_code_nxt  = r_err_code;
        w_buf_we        = 1'b0;

        case (r_state)
            ST_HUNT: begin
                if (bus.din_valid && (bus.din == SYNC_BYTE)) begin
                    w_state_nxt = ST_LEN;
                    w_timer_nxt = '0;
                end
            end

            ST_LEN: begin
                // A byte arriving in the terminal timer cycle takes priority
                // over the timeout in every in-frame state.
                if (bus.din_valid) begin
                    w_timer_nxt = '0;
                    if ((bus.din == 8'h00) || (bus.din > c_max_len)) begin
                        w_frame_err_nxt = 1'b1;
                        w_err_code_nxt  = c_err_bad_len;
                        w_state_nxt     = ST_HUNT;
                    end else begin
                        w_len_nxt    = bus.din;
                        w_sum_nxt    = bus.din;
                        w_wr_ptr_nxt = '0;
                        w_state_nxt  = ST_PAYLOAD;
                    end
                end else if (w_timeout) begin
                    w_frame_err_nxt = 1'b1;
                    w_err_code_nxt  = c_err_timeout;
                    w_state_nxt     = ST_HUNT;
                end else begin
                    w_timer_nxt = r_timer + TIMER_W'(1);
                end
            end

            ST_PAYLOAD: begin
                if (bus.din_valid) begin
                    w_timer_nxt = '0;
                    w_buf_we    = 1'b1;
                    w_sum_nxt   = r_sum + bus.din;
                    // Pointer is not advanced past the last slot so it never
                    // wraps when L == MAX_LEN is a power of two.
                    if (8'(r_wr_ptr) == (r_len - 8'd1)) begin
                        w_state_nxt = ST_CHK;
                    end else begin
                        w_wr_ptr_nxt = r_wr_ptr + PTR_W'(1);
                    end
                end else if (w_timeout) begin
                    w_frame_err_nxt = 1'b1;
                    w_err_code_nxt  = c_err_timeout;
                    w_state_nxt     = ST_HUNT;
                end else begin
                    w_timer_nxt = r_timer + TIMER_W'(1);
                end
            end

            ST_CHK: begin
                if (bus.din_valid) begin
                    w_timer_nxt = '0;
                    if (bus.din == r_sum) begin
                        w_frame_ok_nxt = 1'b1;
                        w_rd_ptr_nxt   = '0;
                        w_state_nxt    = ST_DRAIN;
                    end else begin
                        w_frame_err_nxt = 1'b1;
                        w_err_code_nxt  = c_err_bad_chk;
                        w_state_nxt     = ST_HUNT;
                    end
                end else if (w_timeout) begin
                    w_frame_err_nxt = 1'b1;
                    w_err_code_nxt  = c_err_timeout;
                    w_state_nxt     = ST_HUNT;
                end else begin
                    w_timer_nxt = r_timer + TIMER_W'(1);
                end
            end

            ST_DRAIN: begin
                // Incoming bytes cannot be buffered while draining; they are
                // dropped and flagged, the drain itself is unaffected.
                if (bus.din_valid) begin
                    w_frame_err_nxt = 1'b1;
                    w_err_code_nxt  = c_err_overrun;
                end
                if (bus.dout_ready) begin
                    if (w_rd_last) begin
                        w_state_nxt = ST_HUNT;
                    end else begin
                        w_rd_ptr_nxt = r_rd_ptr + PTR_W'(1);
                    end
                end
            end

            default: begin
                w_state_nxt = ST_HUNT;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_parser.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_frame_parser
//  Description : Self-checking bench for uart_frame_parser. Expected payload
//                bytes and error codes are queued as stimulus is driven and
//                compared as the DUT emits them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_frame_parser;

    localparam int MAX_LEN = 16;
    localparam int TIMEOUT = 20_000;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_frame_parser_if bus ();

    uart_frame_parser #(
        .MAX_LEN      (MAX_LEN),
        .SYNC_BYTE    (8'hA5),
        .TIMEOUT_CLKS (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         total = 0;
    int         bad   = 0;
    int         n_ok  = 0;
    exp_t       exp_q [$];
    logic [2:0] err_q [$];

    // Scoreboard: accepted payload bytes and error pulses against queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.dout_valid && bus.dout_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL dout_unexpected got=%h last=%b expected=none", bus.dout, bus.dout_last);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (bus.dout !== e.data || bus.dout_last !== e.last) begin
                        bad++;
                        $display("FAIL dout got=%h/%b expected=%h/%b", bus.dout, bus.dout_last, e.data, e.last);
                    end
                end
            end
            if (bus.frame_err) begin
                total++;
                if (err_q.size() == 0) begin
                    bad++;
                    $display("FAIL frame_err_unexpected code=%0d expected=none", bus.err_code);
                end else begin
                    logic [2:0] ec;
                    ec = err_q.pop_front();
                    if (bus.err_code !== ec) begin
                        bad++;
                        $display("FAIL err_code got=%0d expected=%0d", bus.err_code, ec);
                    end
                end
            end
            if (bus.frame_ok) n_ok++;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog simulation did not finish, got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        bus.din       = b;
        bus.din_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.din_valid = 1'b0;
    endtask

    // Payload byte i = base + i*step; checksum modelled as L + sum(payload)
    // mod 256, optionally corrupted by chk_xor.
    task automatic send_frame(input logic [7:0] len, input logic [7:0] base,
                              input logic [7:0] step, input logic [7:0] chk_xor);
        logic [7:0] sum;
        logic [7:0] b;
        exp_t       e;
        sum = len;
        send_byte(8'hA5);
        send_byte(len);
        for (int i = 0; i < int'(len); i++) begin
            b   = base + 8'(i) * step;
            sum = sum + b;
            if (chk_xor == 8'h00) begin
                e.data = b;
                e.last = (i == int'(len) - 1);
                exp_q.push_back(e);
            end
            send_byte(b);
        end
        if (chk_xor != 8'h00) err_q.push_back(3'd2);
        send_byte(sum ^ chk_xor);
    endtask

    task automatic wait_idle(input int budget, output logic ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (exp_q.size() == 0 && bus.dout_valid !== 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.din = 8'h00; bus.din_valid = 1'b0; bus.dout_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (bus.dout_valid !== 1'b0) begin bad++; $display("FAIL reset_dout_valid got=%b expected=0", bus.dout_valid); end
        total++; if (bus.dout_last  !== 1'b0) begin bad++; $display("FAIL reset_dout_last got=%b expected=0", bus.dout_last); end
        total++; if (bus.frame_ok   !== 1'b0) begin bad++; $display("FAIL reset_frame_ok got=%b expected=0", bus.frame_ok); end
        total++; if (bus.frame_err  !== 1'b0) begin bad++; $display("FAIL reset_frame_err got=%b expected=0", bus.frame_err); end
        total++; if (bus.err_code   !== 3'd0) begin bad++; $display("FAIL reset_err_code got=%0d expected=0", bus.err_code); end
        total++; if (bus.dout       !== 8'h00) begin bad++; $display("FAIL reset_dout got=%h expected=00", bus.dout); end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_good_frame();
        int   ok0;
        logic ok;
        ok0 = n_ok;
        bus.dout_ready = 1'b1;
        send_frame(8'd3, 8'h11, 8'h11, 8'h00);
        total++;
        if (bus.frame_ok !== 1'b1 || bus.dout_valid !== 1'b1 || bus.dout !== 8'h11) begin
            bad++;
            $display("FAIL good_latency got=ok%b/v%b/%h expected=ok1/v1/11", bus.frame_ok, bus.dout_valid, bus.dout);
        end
        wait_idle(100, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL good_drain got=stuck expected=drained"); end
        total++; if (n_ok - ok0 !== 1) begin bad++; $display("FAIL good_ok_count got=%0d expected=1", n_ok - ok0); end
    endtask

    task automatic test_bad_chk();
        logic ok;
        int   ok0;
        ok0 = n_ok;
        send_frame(8'd2, 8'h10, 8'h10, 8'h03);
        repeat (2) @(posedge clk);
        #1;
        total++; if (bus.err_code !== 3'd2) begin bad++; $display("FAIL badchk_code got=%0d expected=2", bus.err_code); end
        total++; if (err_q.size() !== 0) begin bad++; $display("FAIL badchk_missing got=%0d pending expected=0", err_q.size()); end
        total++; if (n_ok !== ok0) begin bad++; $display("FAIL badchk_ok got=%0d expected=%0d", n_ok, ok0); end
        send_frame(8'd2, 8'h10, 8'h10, 8'h00);
        wait_idle(100, ok);
        total++; if (ok !== 1'b1 || n_ok - ok0 !== 1) begin bad++; $display("FAIL badchk_recover got=%b/%0d expected=1/1", ok, n_ok - ok0); end
    endtask

    task automatic test_bad_len();
        logic ok;
        int   ok0;
        err_q.push_back(3'd1);
        send_byte(8'hA5); send_byte(8'h00);
        @(posedge clk); #1;
        total++; if (bus.err_code !== 3'd1 || err_q.size() !== 0) begin bad++; $display("FAIL badlen_zero got=%0d/%0d expected=1/0", bus.err_code, err_q.size()); end
        err_q.push_back(3'd1);
        send_byte(8'hA5); send_byte(8'h11);
        @(posedge clk); #1;
        total++; if (bus.err_code !== 3'd1 || err_q.size() !== 0) begin bad++; $display("FAIL badlen_big got=%0d/%0d expected=1/0", bus.err_code, err_q.size()); end
        // Second A5 is a length, not a new SYNC; the following bytes are dropped in HUNT.
        ok0 = n_ok;
        err_q.push_back(3'd1);
        send_byte(8'hA5); send_byte(8'hA5);
        send_byte(8'h01); send_byte(8'h7F); send_byte(8'h80);
        repeat (3) @(posedge clk); #1;
        total++; if (n_ok !== ok0 || err_q.size() !== 0) begin bad++; $display("FAIL badlen_noresync got=%0d/%0d expected=%0d/0", n_ok, err_q.size(), ok0); end
        send_frame(8'd16, 8'h01, 8'h01, 8'h00);
        wait_idle(100, ok);
        total++; if (ok !== 1'b1 || n_ok - ok0 !== 1) begin bad++; $display("FAIL maxlen_frame got=%b/%0d expected=1/1", ok, n_ok - ok0); end
    endtask

    task automatic test_timeout();
        int hit;
        hit = -1;
        err_q.push_back(3'd3);
        send_byte(8'hA5); send_byte(8'h04); send_byte(8'h01);
        for (int k = 1; k <= TIMEOUT + 10; k++) begin
            @(posedge clk);
            #1;
            if (bus.frame_err === 1'b1) begin
                hit = k;
                break;
            end
        end
        total++; if (hit !== TIMEOUT) begin bad++; $display("FAIL timeout_cycles got=%0d expected=%0d", hit, TIMEOUT); end
        @(posedge clk); #1;
        total++; if (bus.err_code !== 3'd3 || err_q.size() !== 0) begin bad++; $display("FAIL timeout_code got=%0d/%0d expected=3/0", bus.err_code, err_q.size()); end
    endtask

    task automatic test_overrun();
        logic ok;
        bus.dout_ready = 1'b0;
        send_frame(8'd3, 8'hAA, 8'h11, 8'h00);
        for (int c = 0; c < 50; c++) begin
            if (c == 10) begin
                err_q.push_back(3'd4);
                bus.din = 8'h5A; bus.din_valid = 1'b1;
            end else begin
                bus.din_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            total++;
            if (bus.dout_valid !== 1'b1 || bus.dout !== 8'hAA || bus.dout_last !== 1'b0) begin
                bad++;
                $display("FAIL overrun_hold cycle=%0d got=v%b/%h/%b expected=v1/aa/0", c, bus.dout_valid, bus.dout, bus.dout_last);
            end
        end
        bus.din_valid = 1'b0;
        total++; if (bus.err_code !== 3'd4 || err_q.size() !== 0) begin bad++; $display("FAIL overrun_code got=%0d/%0d expected=4/0", bus.err_code, err_q.size()); end
        bus.dout_ready = 1'b1;
        wait_idle(100, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL overrun_drain got=stuck expected=drained"); end
    endtask

    task automatic test_reset_mid();
        logic ok;
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h01);
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (bus.dout_valid !== 1'b0 || bus.frame_err !== 1'b0 || bus.err_code !== 3'd0 || bus.dout !== 8'h00) begin
            bad++;
            $display("FAIL async_reset got=v%b/e%b/%0d/%h expected=v0/e0/0/00", bus.dout_valid, bus.frame_err, bus.err_code, bus.dout);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        send_byte(8'h55); send_byte(8'hAA);
        send_frame(8'd1, 8'h7F, 8'h00, 8'h00);
        wait_idle(100, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL reset_recover got=stuck expected=drained"); end
    endtask

    task automatic test_back_to_back();
        logic ok;
        int   ok0;
        ok0 = n_ok;
        bus.dout_ready = 1'b1;
        send_frame(8'd1, 8'h05, 8'h00, 8'h00);
        @(posedge clk); #1;
        send_frame(8'd1, 8'h07, 8'h00, 8'h00);
        wait_idle(100, ok);
        total++; if (ok !== 1'b1 || n_ok - ok0 !== 2) begin bad++; $display("FAIL back_to_back got=%b/%0d expected=1/2", ok, n_ok - ok0); end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_chk();
        test_bad_len();
        test_timeout();
        test_overrun();
        test_reset_mid();
        test_back_to_back();
        total++;
        if (exp_q.size() !== 0 || err_q.size() !== 0) begin
            bad++;
            $display("FAIL leftover got=%0d/%0d expected=0/0", exp_q.size(), err_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
